logic_bist_controller: RTL
==========================

# logic_bist_controller

Built-in self-test sequencer for the two-input STA logic chain (`i_a`/`i_b` → `o_y`, optional internal pipeline register). The block generates pseudo-random input pairs with an LFSR and drives them into the chain for a programmed number of patterns. It compacts the sampled responses into a MISR signature and compares the result against a runtime golden value. It sits between the chain and the SoC control/status registers.

## Interface
- `N_PATTERNS`, 1024: patterns applied per run; legal range 1..65535.
- `LATENCY`, 1: clock edges from pattern presentation to response sampling; legal range 0..7 (0 = purely combinational DUT path).
- `SEED`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.
- `i_clk  in  1`: clock.
- `i_rst_n  in  1`: reset, asynchronous, active-low.
- `i_start  in  1`: start pulse; sampled only in IDLE or DONE.
- `i_abort  in  1`: abort; effective in any non-IDLE state.
- `i_golden  in  16`: expected signature; sampled in CHECK.
- `o_dut_a  out  1`: drives chain `i_a`.
- `o_dut_b  out  1`: drives chain `i_b`.
- `i_dut_y  in  1`: chain `o_y`.
- `o_busy  out  1`: high in SEED, RUN, DRAIN and CHECK.
- `o_done  out  1`: high in DONE.
- `o_pass  out  1`: result flag; valid while `o_done` is high.
- `o_signature  out  16`: current MISR contents.
- `o_resp_cnt  out  16`: number of responses absorbed in the current or last run.

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN, CHECK, DONE.
- Transitions:
  - IDLE/DONE → SEED on `i_start`.
  - SEED → RUN.
  - RUN → DRAIN after N_PATTERNS cycles; RUN → CHECK directly if LATENCY = 0.
  - DRAIN → CHECK after LATENCY cycles.
  - CHECK → DONE.
  - DONE holds until the next `i_start`.
- SEED cycle: LFSR ← SEED; MISR ← 0; `o_resp_cnt` ← 0; pattern counter ← 0; `o_pass` ← 0.
- LFSR (Fibonacci, x^16+x^14+x^13+x^11+1):
  - `fb = l[15]^l[13]^l[12]^l[10]`; next `l = {l[14:0], fb}`.
  - Advances once per RUN cycle only.
- Pattern drive:
  - During RUN, `o_dut_a = lfsr[0]` and `o_dut_b = lfsr[1]`, decoded from registered state.
  - Both outputs are 0 in every other state.
- Response capture:
  - A valid shift line of LATENCY stages is fed by `state==RUN`.
  - When its output is high (the RUN flag directly if LATENCY = 0), `i_dut_y` is sampled.
  - Each sample updates the MISR as `m ← {m[14:0], m[15]^m[13]^m[12]^m[10]^i_dut_y}` and increments `o_resp_cnt`.
  - Exactly N_PATTERNS responses are absorbed per run.
- CHECK: `o_pass ← (MISR == i_golden) && (o_resp_cnt == N_PATTERNS)`.
- `i_abort`: the next state is IDLE. The valid line is flushed. MISR, counters and `o_pass` are cleared. `o_done` stays 0. Abort takes priority over every other transition.
- `i_start` while busy: ignored. `i_start` in DONE: restarts the run and clears `o_done` on the next edge.
- Simultaneous `i_start` and `i_abort` in DONE: the abort wins and the state goes to IDLE.

## Timing
- Reset values: state IDLE; LFSR = SEED; MISR = 0; `o_resp_cnt` = 0; `o_busy`, `o_done`, `o_pass`, `o_dut_a`, `o_dut_b` all 0.
- Start sampled at edge E0:
  - SEED during cycle E0..E1.
  - RUN from E1 to E(N+1).
  - DRAIN from E(N+1) to E(N+1+L).
  - CHECK for one cycle.
  - `o_done` and `o_pass` are valid from edge E(N+L+2) onward.
- Pattern k (0-based) is presented from E(k+1) to E(k+2). Its response is sampled at edge E(k+2+L).
- `o_signature` and `o_resp_cnt` are registered and update on the sampling edge.
- Reset asserted mid-run: all registers return to reset values immediately (asynchronous reset); no partial result is reported.

## Structure
- `logic_bist_pkg`:
  - State enum.
  - Polynomial tap constants (16'hB400 mask for bits 15/13/12/10).
  - `DEFAULT_SEED`.
  - Signature width of 16.
- One sub-module, `bist_shift_reg`, a 16-bit tap-feedback shift register with a serial input and an enable. It is instantiated twice:
  - as the LFSR, with serial input 0;
  - as the MISR, with serial input `i_dut_y`.

## Test plan
- LFSR sequence: defaults, start → first RUN cycle a=1, b=0 (lfsr 0xACE1); second cycle a=1, b=1 (lfsr 0x59C3).
- Constant-one response: N_PATTERNS=4, LATENCY=0, `i_dut_y` tied 1 → signature 0x000F, `o_resp_cnt`=4, `o_done` six cycles after start. With golden 0x000F, pass=1; with golden 0x000E, pass=0.
- Latency alignment: N=4, LATENCY=1, bench model y = a|b registered one cycle → signature equals the bench-model MISR and `o_resp_cnt`=4; LATENCY=2 against the same model → pass=0.
- Abort at the third RUN cycle → next cycle state IDLE, `o_busy`=0, `o_done`=0, `o_signature`=0, `o_dut_a`=`o_dut_b`=0.
- `i_start` pulsed during RUN → ignored and completion time unchanged. `i_start` in DONE → a fresh run reproducing the identical signature.
- `i_rst_n` low for one cycle mid-DRAIN → all outputs at reset values; a subsequent start completes normally.

Source files
------------

// File: rtl/logic_bist_pkg.sv
// Shared types and constants for the logic BIST controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_bist_pkg;

  localparam int SIG_W = 16;

  // Feedback taps at bits 15/13/12/10 (x^16+x^14+x^13+x^11+1).
  localparam logic [SIG_W-1:0] TAP_MASK     = 16'hB400;
  localparam logic [SIG_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bist_shift_reg.sv
// Tap-feedback shift register used as both the pattern LFSR and the response MISR.
// Latency: one clock from i_load/i_en to o_q.
// Backpressure: none; i_en simply holds the register when low.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_load_val
//        synchronous load (wins over i_en); i_en shift enable; i_si serial
//        input XORed into the feedback; o_q low OUT_W bits of the register.
module bist_shift_reg
  import logic_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] TAPS    = TAP_MASK,
  parameter logic [SIG_W-1:0] RST_VAL = '0,
  parameter int               OUT_W   = SIG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [SIG_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_si,
  output logic [OUT_W-1:0] o_q
);

  logic [SIG_W-1:0] sr_q, sr_d;
  logic             fb;

  always_comb begin
    fb   = (^(sr_q & TAPS)) ^ i_si;
    sr_d = sr_q;
    if (i_load) begin
      sr_d = i_load_val;
    end else if (i_en) begin
      sr_d = {sr_q[SIG_W-2:0], fb};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_q = sr_q[OUT_W-1:0];

endmodule

// File: rtl/logic_bist_controller.sv
// BIST sequencer: LFSR patterns into the a/b chain, MISR compaction of y, golden compare.
// Latency: done/pass valid N_PATTERNS+LATENCY+2 edges after the start edge.
// Backpressure: none; start is ignored while busy, abort forces IDLE from any state.
// Ports: i_start/i_abort/i_golden control; o_dut_a/o_dut_b/i_dut_y chain
//        stimulus and response; o_busy/o_done/o_pass/o_signature/o_resp_cnt status.
module logic_bist_controller
  import logic_bist_pkg::*;
#(
  parameter int               N_PATTERNS = 1024,
  parameter int               LATENCY    = 1,
  parameter logic [SIG_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [SIG_W-1:0] i_golden,
  output logic             o_dut_a,
  output logic             o_dut_b,
  input  logic             i_dut_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_signature,
  output logic [15:0]      o_resp_cnt
);

  // An all-zero LFSR seed would lock up, so it is replaced by 1.
  localparam logic [SIG_W-1:0] SEED_EFF   = (SEED == '0) ? 16'h0001 : SEED;
  localparam int               VW         = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [15:0]      RUN_LAST   = 16'(N_PATTERNS - 1);
  localparam logic [15:0]      DRAIN_LAST = 16'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [15:0]      N_EXP      = 16'(N_PATTERNS);

  state_e         state_q, state_d;
  logic [15:0]    pat_cnt_q, pat_cnt_d;
  logic [15:0]    resp_cnt_q, resp_cnt_d;
  logic [VW-1:0]  vld_q, vld_d;
  logic           pass_q, pass_d;
  logic           run, sample_en, clear;
  logic [1:0]     lfsr_lo;
  logic [SIG_W-1:0] misr;

  assign run = (state_q == ST_RUN);
  // Response for a pattern arrives LATENCY edges after it was presented.
  assign sample_en = (LATENCY == 0) ? run : vld_q[VW-1];

  always_comb begin
    state_d    = state_q;
    pat_cnt_d  = pat_cnt_q;
    resp_cnt_d = resp_cnt_q;
    pass_d     = pass_q;
    vld_d      = VW'({vld_q, run});
    clear      = 1'b0;

    if (sample_en) begin
      resp_cnt_d = resp_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        clear      = 1'b1;
        pat_cnt_d  = '0;
        resp_cnt_d = '0;
        pass_d     = 1'b0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        pat_cnt_d = pat_cnt_q + 16'd1;
        if (pat_cnt_q == RUN_LAST) begin
          // Counter is reused to time the drain phase.
          pat_cnt_d = '0;
          state_d   = (LATENCY == 0) ? ST_CHECK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pat_cnt_d = pat_cnt_q + 16'd1;
        if (pat_cnt_q == DRAIN_LAST) begin
          pat_cnt_d = '0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pass_d  = (misr == i_golden) && (resp_cnt_q == N_EXP);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_abort) begin
      state_d    = ST_IDLE;
      clear      = 1'b1;
      pat_cnt_d  = '0;
      resp_cnt_d = '0;
      pass_d     = 1'b0;
      vld_d      = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pat_cnt_q  <= '0;
      resp_cnt_q <= '0;
      vld_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_cnt_q  <= pat_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      vld_q      <= vld_d;
      pass_q     <= pass_d;
    end
  end

  bist_shift_reg #(
    .TAPS   (TAP_MASK),
    .RST_VAL(SEED_EFF),
    .OUT_W  (2)
  ) u_lfsr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (clear),
    .i_load_val(SEED_EFF),
    .i_en      (run),
    .i_si      (1'b0),
    .o_q       (lfsr_lo)
  );

  bist_shift_reg #(
    .TAPS   (TAP_MASK),
    .RST_VAL('0),
    .OUT_W  (SIG_W)
  ) u_misr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (clear),
    .i_load_val('0),
    .i_en      (sample_en),
    .i_si      (i_dut_y),
    .o_q       (misr)
  );

  assign o_dut_a     = run & lfsr_lo[0];
  assign o_dut_b     = run & lfsr_lo[1];
  assign o_busy      = (state_q == ST_SEED) || (state_q == ST_RUN) ||
                       (state_q == ST_DRAIN) || (state_q == ST_CHECK);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = pass_q;
  assign o_signature = misr;
  assign o_resp_cnt  = resp_cnt_q;

endmodule
